// File: rtl/codma_task_sched.sv
// codma_task_sched: two-requester descriptor FIFO feeding one DMA engine, one task at a time; CODMA_SCHED_TIMEOUT_EN adds a watchdog.
// An entry accepted into an empty queue with an idle FSM launches 2 cycles later; req_ready_o drops when full, flushing or in reset.
module codma_task_sched #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [1:0]              req_valid_i,
  output logic [1:0]              req_ready_o,
  input  logic [1:0][31:0]        req_task_ptr_i,
  input  logic [1:0][31:0]        req_status_ptr_i,
  output logic                    dma_start_o,
  output logic                    dma_stop_o,
  input  logic                    dma_busy_i,
  output logic [31:0]             dma_task_ptr_o,
  output logic [31:0]             dma_status_ptr_o,
  output logic                    done_valid_o,
  output logic                    done_id_o,
  output logic                    done_err_o,
  output logic                    irq_o,
  input  logic                    irq_clr_i,
  input  logic                    flush_i,
  output logic [$clog2(DEPTH):0]  count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] task_ptr;
    logic [31:0] status_ptr;
    logic        id;
  } entry_t;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_RUN, S_DONE} state_t;

  entry_t        mem [DEPTH];
  entry_t        push_ent;
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          prio;
  logic          has_space;
  logic          contended;
  logic [1:0]    grant;
  logic [1:0]    acc;
  logic          push;
  logic          pop;
  state_t        state;
  logic          cur_id;
  logic          aborted;

`ifdef CODMA_SCHED_TIMEOUT_EN
  localparam int WW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WW-1:0] wd;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Ready looks only at the registered count, so a pop in the same cycle never frees a slot early.
  assign has_space = !reset_i && !flush_i && (cnt != CW'(DEPTH));
  assign contended = &req_valid_i;

  always_comb begin
    grant = 2'b11;
    if (contended) grant = prio ? 2'b10 : 2'b01;
  end

  assign req_ready_o = has_space ? grant : 2'b00;
  assign acc         = req_valid_i & req_ready_o;
  assign push        = |acc;
  assign pop         = (state == S_LAUNCH);
  assign head        = mem[rd_ptr];
  assign count_o     = cnt;

  always_comb begin
    push_ent.task_ptr   = req_task_ptr_i[acc[1]];
    push_ent.status_ptr = req_status_ptr_i[acc[1]];
    push_ent.id         = acc[1];
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_ent;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      prio   <= 1'b0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
      if (push && contended) prio <= ~prio;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state            <= S_IDLE;
      dma_start_o      <= 1'b0;
      dma_stop_o       <= 1'b0;
      dma_task_ptr_o   <= '0;
      dma_status_ptr_o <= '0;
      done_valid_o     <= 1'b0;
      done_id_o        <= 1'b0;
      done_err_o       <= 1'b0;
      irq_o            <= 1'b0;
      cur_id           <= 1'b0;
      aborted          <= 1'b0;
`ifdef CODMA_SCHED_TIMEOUT_EN
      wd               <= '0;
`endif
    end else begin
      dma_start_o  <= 1'b0;
      dma_stop_o   <= 1'b0;
      done_valid_o <= 1'b0;
      if (irq_clr_i) irq_o <= 1'b0;
      case (state)
        S_IDLE: begin
          // A flush in this cycle empties the queue, so the head must not be launched.
          if (cnt != '0 && !flush_i) begin
            state            <= S_LAUNCH;
            dma_start_o      <= 1'b1;
            dma_task_ptr_o   <= head.task_ptr;
            dma_status_ptr_o <= head.status_ptr;
            cur_id           <= head.id;
            aborted          <= 1'b0;
          end
        end
        S_LAUNCH: begin
          state <= S_WAIT_BUSY;
`ifdef CODMA_SCHED_TIMEOUT_EN
          wd    <= '0;
`endif
        end
        S_WAIT_BUSY, S_RUN: begin
          if (flush_i && !aborted) begin
            dma_stop_o <= 1'b1;
            aborted    <= 1'b1;
          end
`ifdef CODMA_SCHED_TIMEOUT_EN
          wd <= wd + WW'(1);
`endif
          if (state == S_WAIT_BUSY && dma_busy_i) begin
            state <= S_RUN;
`ifdef CODMA_SCHED_TIMEOUT_EN
            wd    <= '0;
`endif
          end
          if (state == S_RUN && !dma_busy_i) begin
            state        <= S_DONE;
            done_valid_o <= 1'b1;
            done_id_o    <= cur_id;
            done_err_o   <= aborted || flush_i;
          end
`ifdef CODMA_SCHED_TIMEOUT_EN
          // Stop is raised one cycle ahead so it lands on the last counted cycle.
          if (wd == WW'(TIMEOUT_CYCLES - 2)) dma_stop_o <= 1'b1;
          if (wd == WW'(TIMEOUT_CYCLES - 1)) begin
            state        <= S_DONE;
            done_valid_o <= 1'b1;
            done_id_o    <= cur_id;
            done_err_o   <= 1'b1;
          end
`endif
        end
        S_DONE: begin
          state            <= S_IDLE;
          dma_task_ptr_o   <= '0;
          dma_status_ptr_o <= '0;
          done_id_o        <= 1'b0;
          done_err_o       <= 1'b0;
          irq_o            <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_codma_task_sched.sv
// Bench for codma_task_sched: directed scenarios plus a randomized run against a transaction-level queue model.
module tb_codma_task_sched;
  localparam int DEPTH = 4;
  localparam int TO    = 16;

  typedef struct packed {
    logic [31:0] t;
    logic [31:0] s;
    logic        id;
  } ent_t;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [1:0]       req_valid_i;
  logic [1:0]       req_ready_o;
  logic [1:0][31:0] req_task_ptr_i;
  logic [1:0][31:0] req_status_ptr_i;
  logic             dma_start_o, dma_stop_o, dma_busy_i;
  logic [31:0]      dma_task_ptr_o, dma_status_ptr_o;
  logic             done_valid_o, done_id_o, done_err_o;
  logic             irq_o, irq_clr_i, flush_i;
  logic [2:0]       count_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk_i = ~clk_i;

  codma_task_sched #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_task_ptr_i(req_task_ptr_i), .req_status_ptr_i(req_status_ptr_i),
    .dma_start_o(dma_start_o), .dma_stop_o(dma_stop_o), .dma_busy_i(dma_busy_i),
    .dma_task_ptr_o(dma_task_ptr_o), .dma_status_ptr_o(dma_status_ptr_o),
    .done_valid_o(done_valid_o), .done_id_o(done_id_o), .done_err_o(done_err_o),
    .irq_o(irq_o), .irq_clr_i(irq_clr_i), .flush_i(flush_i), .count_o(count_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic drive_idle();
    req_valid_i      = 2'b00;
    req_task_ptr_i   = '0;
    req_status_ptr_i = '0;
    dma_busy_i       = 1'b0;
    irq_clr_i        = 1'b0;
    flush_i          = 1'b0;
  endtask

  task automatic apply_reset();
    reset_i = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    drive_idle();
    req_valid_i = 2'b11;
    #2;
    n_checks++;
    if ({req_ready_o, dma_start_o, dma_stop_o, dma_task_ptr_o, dma_status_ptr_o, done_valid_o,
         done_id_o, done_err_o, irq_o, count_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b start=%b stop=%b tp=%h sp=%h dv=%b irq=%b cnt=%0d, all required 0",
               req_ready_o, dma_start_o, dma_stop_o, dma_task_ptr_o, dma_status_ptr_o, done_valid_o, irq_o, count_o);
    end
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    #1;
    n_checks++;
    if (req_ready_o !== 2'b01) begin
      n_fail++; $display("FAIL reset_prio: ready=%b required 01", req_ready_o);
    end
    n_checks++;
    if (count_o !== 3'd0) begin
      n_fail++; $display("FAIL reset_count: count=%0d required 0", count_o);
    end
    req_valid_i = 2'b10;
    #1;
    n_checks++;
    if ((req_ready_o & req_valid_i) !== 2'b10) begin
      n_fail++; $display("FAIL single_req1_grant: ready=%b required bit1 set", req_ready_o);
    end
    req_valid_i = 2'b00;
  endtask

  task automatic test_single();
    apply_reset();
    repeat (5) tick();
    req_valid_i = 2'b01;
    req_task_ptr_i[0] = 32'h1000;
    req_status_ptr_i[0] = 32'h2000;
    #1;
    n_checks++;
    if (req_ready_o[0] !== 1'b1) begin n_fail++; $display("FAIL single_ready: %b required 1", req_ready_o[0]); end
    tick(); // cycle 6
    req_valid_i = 2'b00;
    n_checks++;
    if ({dma_start_o, count_o} !== {1'b0, 3'd1}) begin
      n_fail++; $display("FAIL single_c6: start=%b cnt=%0d required 0/1", dma_start_o, count_o);
    end
    tick(); // cycle 7
    n_checks++;
    if ({dma_start_o, dma_task_ptr_o, dma_status_ptr_o} !== {1'b1, 32'h1000, 32'h2000}) begin
      n_fail++; $display("FAIL single_launch: start=%b tp=%h sp=%h required 1/1000/2000",
                         dma_start_o, dma_task_ptr_o, dma_status_ptr_o);
    end
    tick(); // cycle 8, WAIT_BUSY
    n_checks++;
    if (dma_start_o !== 1'b0) begin n_fail++; $display("FAIL single_start_pulse: start=%b required 0", dma_start_o); end
    dma_busy_i = 1'b1;
    tick();
    tick();
    n_checks++;
    if (dma_task_ptr_o !== 32'h1000) begin n_fail++; $display("FAIL single_ptr_hold: tp=%h required 1000", dma_task_ptr_o); end
    tick(); // cycle 11
    dma_busy_i = 1'b0;
    tick(); // cycle 12, DONE
    n_checks++;
    if ({done_valid_o, done_id_o, done_err_o} !== 3'b100) begin
      n_fail++; $display("FAIL single_done: dv/id/err=%b%b%b required 100", done_valid_o, done_id_o, done_err_o);
    end
    tick();
    n_checks++;
    if ({done_valid_o, irq_o, dma_task_ptr_o} !== {1'b0, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL single_after: dv=%b irq=%b tp=%h required 0/1/0", done_valid_o, irq_o, dma_task_ptr_o);
    end
  endtask

  task automatic test_round_robin();
    ent_t       q[$];
    ent_t       e;
    int         k[2];
    int         m_cnt;
    int         start_cyc;
    logic       prio;
    logic       st;
    logic [1:0] exp;
    apply_reset();
    k[0] = 0; k[1] = 0; m_cnt = 0; prio = 1'b0; start_cyc = -10;
    for (int c = 0; c < 8; c++) begin
      st = dma_start_o;
      if (st) begin
        e = q.pop_front();
        n_checks++;
        if ({dma_task_ptr_o, dma_status_ptr_o} !== {e.t, e.s}) begin
          n_fail++; $display("FAIL rr_fill_launch: tp=%h sp=%h required %h/%h", dma_task_ptr_o, dma_status_ptr_o, e.t, e.s);
        end
      end
      n_checks++;
      if (count_o !== m_cnt[2:0]) begin n_fail++; $display("FAIL rr_count: %0d required %0d", count_o, m_cnt); end
      req_valid_i = 2'b11;
      for (int r = 0; r < 2; r++) begin
        req_task_ptr_i[r]   = (r == 0 ? 32'hA000_0000 : 32'hB000_0000) + k[r];
        req_status_ptr_i[r] = req_task_ptr_i[r] ^ 32'h00FF_0000;
      end
      #1;
      exp = (m_cnt < DEPTH) ? (prio ? 2'b10 : 2'b01) : 2'b00;
      n_checks++;
      if (req_ready_o !== exp) begin n_fail++; $display("FAIL rr_ready: %b required %b (cycle %0d)", req_ready_o, exp, cyc); end
      if (exp != 2'b00) begin
        q.push_back('{t: req_task_ptr_i[prio], s: req_status_ptr_i[prio], id: prio});
        k[prio]++;
        prio = ~prio;
        m_cnt++;
      end
      if (st) m_cnt--;
      tick();
    end
    req_valid_i = 2'b00;
    n_checks++;
    if (count_o !== 3'd4) begin n_fail++; $display("FAIL rr_full: count=%0d required 4", count_o); end
    start_cyc = cyc - 1;
    for (int c = 0; c < 40; c++) begin
      if (dma_start_o) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rr_extra_launch: launch with no queued entry, required none");
        end else begin
          e = q.pop_front();
          if ({dma_task_ptr_o, dma_status_ptr_o} !== {e.t, e.s}) begin
            n_fail++; $display("FAIL rr_order: tp=%h sp=%h required %h/%h", dma_task_ptr_o, dma_status_ptr_o, e.t, e.s);
          end
        end
        start_cyc = cyc;
      end
      dma_busy_i = (cyc == start_cyc + 1);
      tick();
    end
    dma_busy_i = 1'b0;
    n_checks++;
    if (q.size() != 0 || count_o !== 3'd0) begin
      n_fail++; $display("FAIL rr_drain: %0d entries never launched, count=%0d required 0/0", q.size(), count_o);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      req_valid_i = 2'b01;
      req_task_ptr_i[0] = 32'h3000 + 32'(c * 16);
      req_status_ptr_i[0] = 32'h4000 + 32'(c * 16);
      if (c == 3) dma_busy_i = 1'b1;
      tick();
    end
    req_valid_i = 2'b00;
    n_checks++;
    if (count_o !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count: %0d required 3", count_o); end
    tick(); // cycle 5, RUN
    flush_i = 1'b1;
    req_valid_i = 2'b01;
    #1;
    n_checks++;
    if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL flush_ready: %b required 00", req_ready_o); end
    tick();
    flush_i = 1'b0;
    req_valid_i = 2'b00;
    n_checks++;
    if ({dma_stop_o, count_o} !== {1'b1, 3'd0}) begin
      n_fail++; $display("FAIL flush_stop: stop=%b count=%0d required 1/0", dma_stop_o, count_o);
    end
    tick();
    n_checks++;
    if (dma_stop_o !== 1'b0) begin n_fail++; $display("FAIL flush_stop_pulse: stop=%b required 0", dma_stop_o); end
    dma_busy_i = 1'b0;
    tick();
    n_checks++;
    if ({done_valid_o, done_err_o} !== 2'b11) begin
      n_fail++; $display("FAIL flush_done_err: dv=%b err=%b required 1/1", done_valid_o, done_err_o);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if ({dma_start_o, count_o} !== 4'b0) begin
        n_fail++; $display("FAIL flush_no_relaunch: start=%b count=%0d required 0/0", dma_start_o, count_o);
      end
    end
  endtask

  task automatic test_irq_clr();
    apply_reset();
    req_valid_i = 2'b01;
    req_task_ptr_i[0] = 32'h7700;
    tick();
    req_valid_i = 2'b00;
    tick();
    tick();
    dma_busy_i = 1'b1;
    tick();
    dma_busy_i = 1'b0;
    tick(); // DONE
    n_checks++;
    if (done_valid_o !== 1'b1) begin n_fail++; $display("FAIL irq_done: dv=%b required 1", done_valid_o); end
    irq_clr_i = 1'b1;
    tick();
    n_checks++;
    if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins: irq=%b required 1", irq_o); end
    tick();
    irq_clr_i = 1'b0;
    n_checks++;
    if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_clear: irq=%b required 0", irq_o); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req_valid_i = 2'b01;
    req_task_ptr_i[0] = 32'h5000;
    req_status_ptr_i[0] = 32'h6000;
    tick();
    req_valid_i = 2'b00;
    tick();
    tick();
    dma_busy_i = 1'b1;
    tick(); // RUN
    n_checks++;
    if (dma_task_ptr_o !== 32'h5000) begin n_fail++; $display("FAIL rstmid_pre: tp=%h required 5000", dma_task_ptr_o); end
    reset_i = 1'b1;
    #1;
    n_checks++;
    if ({req_ready_o, dma_start_o, dma_stop_o, dma_task_ptr_o, dma_status_ptr_o, done_valid_o,
         done_id_o, done_err_o, irq_o, count_o} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: tp=%h sp=%h cnt=%0d irq=%b required all 0",
                         dma_task_ptr_o, dma_status_ptr_o, count_o, irq_o);
    end
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    dma_busy_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if ({done_valid_o, irq_o, dma_start_o} !== 3'b000) begin
        n_fail++; $display("FAIL rstmid_after: dv=%b irq=%b start=%b required 000", done_valid_o, irq_o, dma_start_o);
      end
    end
  endtask

`ifdef CODMA_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    req_valid_i = 2'b01;
    req_task_ptr_i[0] = 32'h9000;
    tick();
    req_valid_i = 2'b00;
    tick(); // LAUNCH
    for (int k = 1; k <= TO; k++) begin
      tick();
      n_checks++;
      if ({dma_stop_o, done_valid_o} !== {(k == TO), 1'b0}) begin
        n_fail++; $display("FAIL timeout_stop: wait cycle %0d stop=%b dv=%b required %b/0", k, dma_stop_o, done_valid_o, k == TO);
      end
    end
    tick();
    n_checks++;
    if ({done_valid_o, done_err_o, dma_stop_o} !== 3'b110) begin
      n_fail++; $display("FAIL timeout_done: dv=%b err=%b stop=%b required 1/1/0", done_valid_o, done_err_o, dma_stop_o);
    end
  endtask
`else
  task automatic test_timeout();
    apply_reset();
    req_valid_i = 2'b01;
    tick();
    req_valid_i = 2'b00;
    tick();
    for (int k = 1; k <= 3 * TO; k++) begin
      tick();
      n_checks++;
      if ({dma_stop_o, done_valid_o} !== 2'b00) begin
        n_fail++; $display("FAIL no_watchdog: wait cycle %0d stop=%b dv=%b required 0/0", k, dma_stop_o, done_valid_o);
      end
    end
  endtask
`endif

  task automatic test_random();
    ent_t       q[$];
    ent_t       cur;
    int         m_cnt, bf, bt, done_at, free_at, w, b;
    logic       prio, exp_start, m_irq, st, sel;
    logic [1:0] exp_acc;
    apply_reset();
    m_cnt = 0; prio = 1'b0; exp_start = 1'b0; m_irq = 1'b0;
    bf = -1; bt = -1; done_at = -1; free_at = 0;
    cur = '0;
    for (int i = 0; i < 800; i++) begin
      st = dma_start_o;
      n_checks++;
      if (count_o !== m_cnt[2:0]) begin n_fail++; $display("FAIL rnd_count: %0d required %0d at %0d", count_o, m_cnt, cyc); end
      n_checks++;
      if (st !== exp_start) begin n_fail++; $display("FAIL rnd_start: %b required %b at %0d", st, exp_start, cyc); end
      if (st === 1'b1) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd_launch_empty: launch at %0d with model queue empty", cyc);
        end else begin
          cur = q.pop_front();
          if ({dma_task_ptr_o, dma_status_ptr_o} !== {cur.t, cur.s}) begin
            n_fail++; $display("FAIL rnd_ptrs: %h/%h required %h/%h", dma_task_ptr_o, dma_status_ptr_o, cur.t, cur.s);
          end
        end
        w = $urandom_range(0, 3);
        b = $urandom_range(1, 4);
        bf = cyc + 1 + w;
        bt = cyc + w + b;
        done_at = cyc + 2 + w + b;
        free_at = done_at + 1;
      end
      n_checks++;
      if (done_valid_o !== (cyc == done_at)) begin
        n_fail++; $display("FAIL rnd_done_valid: %b required %b at %0d", done_valid_o, cyc == done_at, cyc);
      end
      if (cyc == done_at) begin
        n_checks++;
        if ({done_id_o, done_err_o} !== {cur.id, 1'b0}) begin
          n_fail++; $display("FAIL rnd_done_id: id=%b err=%b required %b/0", done_id_o, done_err_o, cur.id);
        end
      end
      n_checks++;
      if (irq_o !== m_irq) begin n_fail++; $display("FAIL rnd_irq: %b required %b at %0d", irq_o, m_irq, cyc); end
      exp_start = (cyc >= free_at) && (m_cnt > 0);
      req_valid_i = 2'($urandom_range(0, 3));
      for (int r = 0; r < 2; r++) begin
        req_task_ptr_i[r]   = $urandom;
        req_status_ptr_i[r] = $urandom;
      end
      dma_busy_i = (cyc >= bf) && (cyc <= bt);
      irq_clr_i  = ($urandom_range(0, 7) == 0);
      #1;
      if (m_cnt >= DEPTH) exp_acc = 2'b00;
      else if (req_valid_i == 2'b11) exp_acc = prio ? 2'b10 : 2'b01;
      else exp_acc = req_valid_i;
      n_checks++;
      if ((req_ready_o & req_valid_i) !== exp_acc) begin
        n_fail++; $display("FAIL rnd_grant: ready=%b valid=%b required grant %b at %0d", req_ready_o, req_valid_i, exp_acc, cyc);
      end
      if (exp_acc != 2'b00) begin
        sel = exp_acc[1];
        q.push_back('{t: req_task_ptr_i[sel], s: req_status_ptr_i[sel], id: sel});
        m_cnt++;
        if (req_valid_i == 2'b11) prio = ~prio;
      end
      if (st === 1'b1) m_cnt--;
      m_irq = (cyc == done_at) ? 1'b1 : (irq_clr_i ? 1'b0 : m_irq);
      tick();
    end
    drive_idle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_flush();
    test_irq_clr();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/codma_task_sched.md
CODMA_TASK_SCHED -- requirements
Module: codma_task_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit (used only with CODMA_SCHED_TIMEOUT_EN).
REQ-003 SHALL have port clk_i  in  1  clock; all state on rising edge.
REQ-004 SHALL have port reset_i  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req_valid_i  in  2  and req_ready_o  out  2  per-requester push handshake.
REQ-006 SHALL have ports req_task_ptr_i  in  2x32  and req_status_ptr_i  in  2x32  descriptor pointers per requester.
REQ-007 SHALL have ports dma_start_o  out  1, dma_stop_o  out  1, dma_busy_i  in  1  engine control.
REQ-008 SHALL have ports dma_task_ptr_o  out  32  and dma_status_ptr_o  out  32  pointers to engine.
REQ-009 SHALL have ports done_valid_o  out  1, done_id_o  out  1, done_err_o  out  1  completion report.
REQ-010 SHALL have ports irq_o  out  1, irq_clr_i  in  1, flush_i  in  1, count_o  out  $clog2(DEPTH)+1  occupancy.

Function
REQ-011 SHALL queue entries {task_ptr, status_ptr, id} in FIFO order; accept requester i when req_valid_i[i] and req_ready_o[i] at a rising edge.
REQ-012 SHALL drive req_ready_o from registered count only: zero when count_o==DEPTH or flush_i=1; a same-cycle pop does not free a slot.
REQ-013 SHALL accept at most one push per cycle; single valid requester always granted; both valid -> round-robin, priority pointer toggles after each contended accept.
REQ-014 SHALL run FSM IDLE->LAUNCH when count_o>0; LAUNCH->WAIT_BUSY unconditionally; WAIT_BUSY->RUN on dma_busy_i=1; RUN->DONE on dma_busy_i=0; DONE->IDLE unconditionally.
REQ-015 SHALL assert dma_start_o for exactly the LAUNCH cycle and pop the head entry at the end of that cycle.
REQ-016 SHALL hold dma_task_ptr_o/dma_status_ptr_o stable from LAUNCH through DONE; zero in IDLE.
REQ-017 SHALL, with empty queue and FSM in IDLE, assert dma_start_o in cycle C+2 for an entry accepted in cycle C.
REQ-018 SHALL pulse done_valid_o for the DONE cycle only, done_id_o = requester id of the entry, done_err_o = 1 if the task was aborted.
REQ-019 SHALL set irq_o on DONE and clear it on irq_clr_i; set wins over simultaneous clear.
REQ-020 SHALL on flush_i empty the queue at the next edge (push in same cycle not accepted); in WAIT_BUSY or RUN pulse dma_stop_o one cycle, mark task aborted, continue normal transitions.
REQ-021 SHALL ignore flush_i in LAUNCH for the in-flight entry (already popped) but still empty the queue.

Reset
REQ-022 SHALL on reset_i=1 immediately force FSM IDLE, queue empty, count_o=0, round-robin priority to requester 0, all outputs 0.
REQ-023 SHALL, on reset mid-task, drop the task without done_valid_o or irq_o; dma_start_o/dma_stop_o go low asynchronously.

Configuration
REQ-024 SHALL, with CODMA_SCHED_TIMEOUT_EN defined, count cycles in WAIT_BUSY and RUN (reset on entry); at TIMEOUT_CYCLES pulse dma_stop_o, go to DONE with done_err_o=1.
REQ-025 SHALL, without CODMA_SCHED_TIMEOUT_EN, contain no watchdog counter; WAIT_BUSY and RUN wait indefinitely.

Verification
REQ-026 SHALL test: req0 pushes task 0x1000/status 0x2000 at cycle 5 -> dma_start_o high cycle 7, ptr outputs 0x1000/0x2000, busy 3 cycles -> done_valid_o, done_id_o=0, irq_o=1.
REQ-027 SHALL test: both requesters valid continuously, DEPTH=4 -> accepts alternate 0,1,0,1, ready drops at count_o=4, launches in same order.
REQ-028 SHALL test: flush_i during RUN with 3 queued -> dma_stop_o one cycle, count_o=0 next cycle, done_err_o=1 when busy falls.
REQ-029 SHALL test: irq_clr_i same cycle as DONE -> irq_o stays 1; irq_clr_i next cycle -> irq_o 0.
REQ-030 SHALL test: with CODMA_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16, busy never asserted -> dma_stop_o at 16th WAIT_BUSY cycle, done_err_o=1.
REQ-031 SHALL test: reset_i asserted in RUN -> all outputs 0 same cycle, no done_valid_o after release.
